// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with 2-flop row synchronizer, ghost rejection and
// frame-based debounce of keys 0..9. Reset is synchronous and active-high.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [9:0] key_value,
  output logic       frame_done
);

  localparam int unsigned DW = $clog2(SCAN_CYCLES);
  localparam int unsigned CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [DW-1:0] DLast  = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic {StScan, StEval} state_e;

  state_e        state_q;
  logic [1:0]    c_q;
  logic [DW-1:0] d_q;
  logic [3:0]    col_q;
  logic          frame_done_q;
  logic [9:0]    key_value_q;
  logic [9:0]    prev_snap_q;
  logic [CW-1:0] stable_cnt_q;
  logic [15:0]   fb_q;
  logic [3:0]    row_meta_q;
  logic [3:0]    row_s_q;

  logic [9:0]    snap_raw;
  logic [9:0]    snap;
  logic [CW-1:0] stable_cnt_d;

  // Keys 10..15 are scanned into the buffer but never reach the snapshot.
  logic unused_fb;
  assign unused_fb = ^fb_q[15:10];

  assign col        = col_q;
  assign frame_done = frame_done_q;
  assign key_value  = key_value_q;

  // Two-flop synchronizer; idle rows read as all ones.
  always_ff @(posedge clk) begin
    if (rstn) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  // Snapshot with multi-key rejection, and the post-update debounce count.
  always_comb begin
    snap_raw = fb_q[9:0];
    snap     = ((snap_raw & (snap_raw - 10'd1)) != 10'd0) ? 10'd0 : snap_raw;
    if (snap != prev_snap_q) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q == CntMax) begin
      stable_cnt_d = stable_cnt_q;
    end else begin
      stable_cnt_d = stable_cnt_q + CW'(1);
    end
  end

  // Scan/eval FSM with registered col, frame_done and key_value.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= StScan;
      c_q          <= 2'd0;
      d_q          <= '0;
      col_q        <= 4'b1110;
      frame_done_q <= 1'b0;
      key_value_q  <= 10'd0;
      prev_snap_q  <= 10'd0;
      stable_cnt_q <= '0;
      fb_q         <= 16'd0;
    end else begin
      unique case (state_q)
        StScan: begin
          frame_done_q <= 1'b0;
          if (d_q == DLast) begin
            fb_q[{c_q, 2'b00} +: 4] <= ~row_s_q;
            d_q <= '0;
            if (c_q != 2'd3) begin
              c_q   <= c_q + 2'd1;
              col_q <= ~(4'b0001 << (c_q + 2'd1));
            end else begin
              state_q      <= StEval;
              col_q        <= 4'b1111;
              frame_done_q <= 1'b1;
            end
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
        StEval: begin
          state_q      <= StScan;
          c_q          <= 2'd0;
          d_q          <= '0;
          col_q        <= 4'b1110;
          frame_done_q <= 1'b0;
          prev_snap_q  <= snap;
          stable_cnt_q <= stable_cnt_d;
          if (stable_cnt_d == CntMax) key_value_q <= snap;
        end
        default: state_q <= StScan;
      endcase
    end
  end

endmodule
